// File: rtl/counter_sweep_ctrl.sv
// Purpose: sweep program controller for an external free-running up/down counter (lo->hi->lo, N times).
// Latency: counter control outputs are combinational; busy/done/cfg_err/sweep_cnt are registered (1 cycle).
// Backpressure: none; start is only accepted in IDLE, and abort preempts any running program.
module counter_sweep_ctrl #(
    parameter int WIDTH = 4,
    parameter int CW    = 4
) (
    input  logic             i_clock,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [WIDTH-1:0] i_cfg_lo,
    input  logic [WIDTH-1:0] i_cfg_hi,
    input  logic [CW-1:0]    i_cfg_sweeps,
    input  logic [WIDTH-1:0] i_cnt_dout,
    output logic             o_cnt_load,
    output logic             o_cnt_mode,
    output logic [WIDTH-1:0] o_cnt_din,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_cfg_err,
    output logic [CW-1:0]    o_sweep_cnt
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_UP   = 3'd2,
        S_DOWN = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_next;

    // Latched program configuration and the value the counter is frozen at while idle.
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_hi;
    logic [CW-1:0]    r_sweeps;
    logic [WIDTH-1:0] r_park;

    logic [CW-1:0]    r_sweep_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_cfg_err;

    logic             w_cfg_ok;
    logic             w_at_lo;
    logic             w_at_hi;
    logic             w_running;
    logic             w_abort;
    logic [CW-1:0]    w_sweep_inc;
    logic             w_last;
    logic             w_accept;
    logic             w_reject;
    logic             w_sweep_step;
    logic             w_cnt_load;
    logic             w_cnt_mode;
    logic [WIDTH-1:0] w_cnt_din;

    assign w_cfg_ok    = (i_cfg_lo < i_cfg_hi);
    assign w_at_lo     = (i_cnt_dout == r_lo);
    assign w_at_hi     = (i_cnt_dout == r_hi);
    assign w_running   = (r_state == S_LOAD) || (r_state == S_UP) || (r_state == S_DOWN);
    assign w_abort     = i_abort && w_running;
    // Saturating increment: the completed-sweep count never wraps back to zero.
    assign w_sweep_inc = (r_sweep_cnt == {CW{1'b1}}) ? r_sweep_cnt : (r_sweep_cnt + CW'(1));
    // Latched sweep count is never zero, so the saturated count always reaches it.
    assign w_last      = (w_sweep_inc >= r_sweeps);

    // Next-state and counter-control decode; abort overrides every transition.
    always_comb begin
        w_next       = r_state;
        w_cnt_load   = 1'b1;
        w_cnt_mode   = 1'b0;
        w_cnt_din    = r_park;
        w_accept     = 1'b0;
        w_reject     = 1'b0;
        w_sweep_step = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Holding load high with the park value freezes the counter.
                w_cnt_load = 1'b1;
                w_cnt_din  = r_park;
                if (i_start && !i_abort) begin
                    if (w_cfg_ok) begin
                        w_accept = 1'b1;
                        w_next   = S_LOAD;
                    end else begin
                        w_reject = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                w_cnt_load = 1'b1;
                w_cnt_din  = r_lo;
                w_cnt_mode = 1'b1;
                w_next     = S_UP;
            end
            S_UP: begin
                // Turning the direction at hi avoids repeating the ceiling value.
                w_cnt_load = 1'b0;
                w_cnt_mode = !w_at_hi;
                if (w_at_hi) begin
                    w_next = S_DOWN;
                end
            end
            S_DOWN: begin
                w_cnt_load = 1'b0;
                w_cnt_mode = w_at_lo && !w_last;
                if (w_at_lo) begin
                    w_sweep_step = 1'b1;
                    w_next       = w_last ? S_DONE : S_UP;
                end
            end
            S_DONE: begin
                w_cnt_load = 1'b1;
                w_cnt_din  = r_lo;
                w_next     = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        if (w_abort) begin
            // Reload the counter with its own value so it stops where it is.
            w_cnt_load   = 1'b1;
            w_cnt_din    = i_cnt_dout;
            w_cnt_mode   = 1'b0;
            w_next       = S_IDLE;
            w_sweep_step = 1'b0;
        end
    end

    assign o_cnt_load = w_cnt_load;
    assign o_cnt_mode = w_cnt_mode;
    assign o_cnt_din  = w_cnt_din;

    // State register.
    always_ff @(posedge i_clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Configuration latch on an accepted start.
    always_ff @(posedge i_clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lo     <= '0;
            r_hi     <= '0;
            r_sweeps <= '0;
        end else if (w_accept) begin
            r_lo     <= i_cfg_lo;
            r_hi     <= i_cfg_hi;
            r_sweeps <= (i_cfg_sweeps == '0) ? CW'(1) : i_cfg_sweeps;
        end
    end

    // Park value: where the counter sits while idle (abort point or sweep floor).
    always_ff @(posedge i_clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_park <= '0;
        end else if (w_abort) begin
            r_park <= i_cnt_dout;
        end else if (r_state == S_DONE) begin
            r_park <= r_lo;
        end
    end

    // Completed-sweep counter, cleared when a new program is accepted.
    always_ff @(posedge i_clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sweep_cnt <= '0;
        end else if (w_accept) begin
            r_sweep_cnt <= '0;
        end else if (w_sweep_step) begin
            r_sweep_cnt <= w_sweep_inc;
        end
    end

    // Registered status flags, decoded from the state being entered.
    always_ff @(posedge i_clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_cfg_err <= 1'b0;
        end else begin
            r_busy    <= (w_next == S_LOAD) || (w_next == S_UP) || (w_next == S_DOWN);
            r_done    <= (w_next == S_DONE);
            r_cfg_err <= w_reject;
        end
    end

    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_cfg_err   = r_cfg_err;
    assign o_sweep_cnt = r_sweep_cnt;

endmodule

// File: doc/counter_sweep_ctrl.md
COUNTER_SWEEP_CTRL -- requirements
Module: counter_sweep_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the counter data width.
REQ-002 SHALL have parameter CW, default 4, giving the sweep-count width.
REQ-003 clock  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 start  in  1  one-cycle request to begin a sweep program.
REQ-006 abort  in  1  stop the program and park the counter.
REQ-007 cfg_lo  in  WIDTH  sweep floor value.
REQ-008 cfg_hi  in  WIDTH  sweep ceiling value.
REQ-009 cfg_sweeps  in  CW  number of up/down sweeps.
REQ-010 cnt_dout  in  WIDTH  current value of the controlled up/down counter.
REQ-011 cnt_load  out  1  counter load strobe.
REQ-012 cnt_mode  out  1  counter direction: 1 = up, 0 = down.
REQ-013 cnt_din  out  WIDTH  counter load value.
REQ-014 busy  out  1  high while a program is running (states LOAD/UP/DOWN).
REQ-015 done  out  1  one-cycle pulse on normal completion.
REQ-016 cfg_err  out  1  one-cycle pulse when start is rejected.
REQ-017 sweep_cnt  out  CW  number of completed sweeps in the current program.

Function
REQ-018 SHALL implement an FSM with states IDLE, LOAD, UP, DOWN and DONE; the counter is free-running and always counts unless loaded.
REQ-019 In IDLE, start=1 and cfg_lo<cfg_hi SHALL latch cfg_lo, cfg_hi and cfg_sweeps, clear sweep_cnt, and go to LOAD.
REQ-020 In IDLE, start=1 with cfg_lo>=cfg_hi SHALL pulse cfg_err next cycle and remain in IDLE.
REQ-021 A latched sweep count of 0 SHALL be treated as 1.
REQ-022 start while busy or in DONE SHALL be ignored, with no cfg_err.
REQ-023 IDLE: cnt_load=1, cnt_din=park register; this freezes the counter.
REQ-024 LOAD: cnt_load=1, cnt_din=lo, cnt_mode=1; lasts one cycle, then UP.
REQ-025 UP: cnt_load=0; cnt_mode = (cnt_dout!=hi). When cnt_dout==hi, next state is DOWN.
REQ-026 DOWN: cnt_load=0; cnt_mode = (cnt_dout==lo && more sweeps remain).
REQ-027 DOWN with cnt_dout==lo SHALL increment sweep_cnt.
  - If the new sweep_cnt equals the latched count, go to DONE.
  - Otherwise go to UP.
REQ-028 DONE: cnt_load=1, cnt_din=lo, done=1 for exactly one cycle; park register := lo; then IDLE.
REQ-029 abort=1 in LOAD, UP or DOWN SHALL, in the same cycle:
  - assert cnt_load=1 with cnt_din=cnt_dout;
  - set park register := cnt_dout;
  - go to IDLE next cycle, with no done pulse.
REQ-030 abort has priority over start and over every FSM transition; abort in IDLE or DONE is a no-op.
REQ-031 Outputs cnt_load, cnt_mode and cnt_din SHALL be combinational from state, latched config and cnt_dout.
  - busy, done, cfg_err and sweep_cnt SHALL be registered.
REQ-032 Comparisons SHALL be unsigned, WIDTH bits; sweep_cnt SHALL saturate, never wrap.

Reset
REQ-033 rst=0 SHALL asynchronously force:
  - state IDLE, park register 0, latched config 0, sweep_cnt 0;
  - busy=0, done=0, cfg_err=0.
REQ-034 During reset and after it, cnt_load=1 and cnt_din=0 (counter parked at 0), with cnt_mode=0.
REQ-035 rst asserted mid-program SHALL abandon the program with no done pulse.

Verification
REQ-036 Reset, then idle 5 cycles: cnt_dout stays 0, busy=0.
REQ-037 lo=2, hi=5, sweeps=1, start: cnt_dout follows 2,3,4,5,4,3,2.
  - done pulses once, sweep_cnt=1.
  - Counter then holds 2 indefinitely.
REQ-038 lo=9, hi=12, sweeps=3: three full 9..12..9 sweeps with no repeated or skipped values at turnarounds.
  - sweep_cnt reads 1, 2, 3; done pulses once after the third sweep.
REQ-039 lo=5, hi=5 start: cfg_err pulses one cycle, busy stays 0, counter unchanged; lo=7, hi=3 behaves the same.
REQ-040 lo=0, hi=15, sweeps=2, abort when cnt_dout=11 in the second sweep: counter holds 11, busy drops next cycle, no done pulse.
  - Then start again with sweeps=0: one sweep runs.
REQ-041 Assert rst while cnt_dout=4 in UP: busy=0 immediately and counter loads 0; start during busy is ignored.
